// File: rtl/can_rec_uplink_arbiter.sv
// Round-robin arbiter that shares the CAN receive uplink among up to 32 buses.
// It selects a requesting bus, captures its frame and offers it to the e-link side.
module can_rec_uplink_arbiter #(
    parameter int N_BUSES     = 32,
    parameter int DATA_W      = 76,
    parameter int TIMEOUT_CYC = 1024,
    parameter int CNT_W       = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               enable,
    input  logic [4:0]         n_buses,
    input  logic [N_BUSES-1:0] irq_can_rec,
    input  logic [DATA_W-1:0]  data_rec_in,
    input  logic               uplink_ready,
    output logic [4:0]         can_rec_select,
    output logic [N_BUSES-1:0] rec_ack,
    output logic [DATA_W-1:0]  data_rec_uplink,
    output logic               uplink_valid,
    output logic               busy,
    output logic               drop_err,
    output logic [CNT_W-1:0]   drop_cnt
);

    localparam int TO_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {
        IDLE,
        SELECT,
        CAPTURE,
        SEND
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [4:0]         ptr;
    logic [4:0]         ptr_nxt;
    logic [TO_W-1:0]    to_cnt;
    logic [N_BUSES-1:0] eligible;
    logic [4:0]         start;
    logic [4:0]         winner;
    logic               found_hi;
    logic               any_req;
    logic [31:0]        irq_ext;
    logic               grant;
    logic               capture;
    logic               handshake;
    logic               drop;

    // Mask out buses above n_buses, then pick the first eligible bus at or above
    // the pointer, falling back to the lowest eligible bus when none is found.
    always_comb begin
        eligible = '0;
        for (int i = 0; i < N_BUSES; i++) begin
            eligible[i] = irq_can_rec[i] && (5'(i) <= n_buses);
        end
        any_req  = |eligible;
        start    = (ptr > n_buses) ? 5'd0 : ptr;
        winner   = 5'd0;
        found_hi = 1'b0;
        for (int i = N_BUSES - 1; i >= 0; i--) begin
            if (eligible[i] && (5'(i) >= start)) begin
                winner   = 5'(i);
                found_hi = 1'b1;
            end
        end
        if (!found_hi) begin
            for (int i = N_BUSES - 1; i >= 0; i--) begin
                if (eligible[i]) begin
                    winner = 5'(i);
                end
            end
        end
    end

    assign irq_ext = 32'(irq_can_rec);
    assign ptr_nxt = (can_rec_select >= n_buses) ? 5'd0 : can_rec_select + 5'd1;

    always_comb begin
        state_nxt = state;
        grant     = 1'b0;
        capture   = 1'b0;
        handshake = 1'b0;
        drop      = 1'b0;
        case (state)
            IDLE: begin
                if (enable && any_req) begin
                    grant     = 1'b1;
                    state_nxt = SELECT;
                end
            end
            SELECT: state_nxt = CAPTURE;
            CAPTURE: begin
                if (irq_ext[can_rec_select]) begin
                    capture   = 1'b1;
                    state_nxt = SEND;
                end else begin
                    state_nxt = IDLE;
                end
            end
            SEND: begin
                // A ready arriving on the expiry cycle still completes the transfer.
                if (uplink_valid && uplink_ready) begin
                    handshake = 1'b1;
                    state_nxt = IDLE;
                end else if (to_cnt == TO_LAST) begin
                    drop      = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            ptr             <= '0;
            to_cnt          <= '0;
            can_rec_select  <= '0;
            rec_ack         <= '0;
            data_rec_uplink <= '0;
            uplink_valid    <= 1'b0;
            busy            <= 1'b0;
            drop_err        <= 1'b0;
            drop_cnt        <= '0;
        end else begin
            state    <= state_nxt;
            busy     <= (state_nxt != IDLE);
            rec_ack  <= '0;
            drop_err <= 1'b0;
            if (grant) begin
                can_rec_select <= winner;
            end
            if (capture) begin
                data_rec_uplink <= data_rec_in;
                uplink_valid    <= 1'b1;
                rec_ack         <= N_BUSES'(32'd1 << can_rec_select);
                to_cnt          <= '0;
            end
            if ((state == SEND) && !handshake && !drop) begin
                to_cnt <= to_cnt + 1'b1;
            end
            if (handshake || drop) begin
                uplink_valid <= 1'b0;
                ptr          <= ptr_nxt;
            end
            if (drop) begin
                drop_err <= 1'b1;
                if (drop_cnt != '1) begin
                    drop_cnt <= drop_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_can_rec_uplink_arbiter.sv
// Directed testbench for can_rec_uplink_arbiter with hand-computed expectations.
module tb_can_rec_uplink_arbiter;

    localparam int N_BUSES     = 32;
    localparam int DATA_W      = 76;
    localparam int TIMEOUT_CYC = 16;
    localparam int CNT_W       = 16;

    logic               clk = 1'b0;
    logic               rst;
    logic               enable;
    logic [4:0]         n_buses;
    logic [N_BUSES-1:0] irq_can_rec;
    logic [DATA_W-1:0]  data_rec_in;
    logic               uplink_ready;
    logic [4:0]         can_rec_select;
    logic [N_BUSES-1:0] rec_ack;
    logic [DATA_W-1:0]  data_rec_uplink;
    logic               uplink_valid;
    logic               busy;
    logic               drop_err;
    logic [CNT_W-1:0]   drop_cnt;

    int assert_cnt = 0;
    int fail_cnt   = 0;

    can_rec_uplink_arbiter #(
        .N_BUSES(N_BUSES),
        .DATA_W(DATA_W),
        .TIMEOUT_CYC(TIMEOUT_CYC),
        .CNT_W(CNT_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .enable(enable),
        .n_buses(n_buses),
        .irq_can_rec(irq_can_rec),
        .data_rec_in(data_rec_in),
        .uplink_ready(uplink_ready),
        .can_rec_select(can_rec_select),
        .rec_ack(rec_ack),
        .data_rec_uplink(data_rec_uplink),
        .uplink_valid(uplink_valid),
        .busy(busy),
        .drop_err(drop_err),
        .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [31:0] irq, input logic [4:0] nb,
                                 input logic en, input logic rdy);
        irq_can_rec  = irq;
        n_buses      = nb;
        enable       = en;
        uplink_ready = rdy;
    endtask

    task automatic checkOutput(input string tag, input logic [127:0] observed,
                               input logic [127:0] expected);
        assert_cnt++;
        assert (observed === expected) else begin
            fail_cnt++;
            $error("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
        end
    endtask

    task automatic checkIdleOutputs(input string tag);
        checkOutput({tag, "_valid"}, 128'(uplink_valid), 128'(0));
        checkOutput({tag, "_ack"},   128'(rec_ack),      128'(0));
        checkOutput({tag, "_busy"},  128'(busy),         128'(0));
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_sel"},   128'(can_rec_select),  128'(0));
        checkOutput({tag, "_data"},  128'(data_rec_uplink), 128'(0));
        checkOutput({tag, "_derr"},  128'(drop_err),        128'(0));
        checkOutput({tag, "_dcnt"},  128'(drop_cnt),        128'(0));
        checkIdleOutputs(tag);
    endtask

    localparam logic [DATA_W-1:0] D_ABC = 76'hABC;
    localparam logic [DATA_W-1:0] D_BP  = 76'h123456789ABCDEF0123;
    localparam logic [DATA_W-1:0] D_ALT = 76'hFEDCBA98765432100FF;

    initial begin
        logic [4:0] fair_order [5];
        fair_order = '{5'd0, 5'd5, 5'd31, 5'd0, 5'd5};

        rst         = 1'b1;
        data_rec_in = '0;
        applyStimulus(32'h0, 5'd31, 1'b1, 1'b1);
        tick();
        tick();
        checkResetOutputs("reset");
        rst = 1'b0;

        $display("[TB] single request on bus 4");
        data_rec_in = D_ABC;
        applyStimulus(32'h1 << 4, 5'd31, 1'b1, 1'b1);
        tick();
        checkOutput("single_sel", 128'(can_rec_select), 128'(4));
        checkOutput("single_busy", 128'(busy), 128'(1));
        checkOutput("single_valid_early", 128'(uplink_valid), 128'(0));
        tick();
        tick();
        checkOutput("single_ack", 128'(rec_ack), 128'(32'h1 << 4));
        checkOutput("single_valid", 128'(uplink_valid), 128'(1));
        checkOutput("single_data", 128'(data_rec_uplink), 128'(D_ABC));
        irq_can_rec = '0;
        tick();
        checkIdleOutputs("single_done");

        $display("[TB] fairness across buses 0, 5, 31");
        rst = 1'b1;
        tick();
        rst = 1'b0;
        applyStimulus((32'h1 << 0) | (32'h1 << 5) | (32'h1 << 31), 5'd31, 1'b1, 1'b1);
        for (int g = 0; g < 5; g++) begin
            tick();
            checkOutput("fair_sel", 128'(can_rec_select), 128'(fair_order[g]));
            tick();
            tick();
            checkOutput("fair_ack", 128'(rec_ack), 128'(32'h1 << fair_order[g]));
            checkOutput("fair_valid", 128'(uplink_valid), 128'(1));
            tick();
            checkOutput("fair_valid_low", 128'(uplink_valid), 128'(0));
        end
        irq_can_rec = '0;

        $display("[TB] masking then backpressure on bus 12");
        applyStimulus(32'h1 << 12, 5'd7, 1'b1, 1'b0);
        data_rec_in = D_BP;
        tick();
        tick();
        tick();
        checkOutput("mask_busy", 128'(busy), 128'(0));
        checkOutput("mask_sel", 128'(can_rec_select), 128'(5));
        n_buses = 5'd15;
        tick();
        checkOutput("unmask_sel", 128'(can_rec_select), 128'(12));
        tick();
        tick();
        data_rec_in = D_ALT;
        for (int i = 0; i < 10; i++) begin
            checkOutput("bp_valid", 128'(uplink_valid), 128'(1));
            checkOutput("bp_data", 128'(data_rec_uplink), 128'(D_BP));
            if (i == 0) checkOutput("bp_ack_first", 128'(rec_ack), 128'(32'h1 << 12));
            if (i == 1) checkOutput("bp_ack_second", 128'(rec_ack), 128'(0));
            tick();
        end
        uplink_ready = 1'b1;
        irq_can_rec  = '0;
        tick();
        checkIdleOutputs("bp_done");
        checkOutput("bp_dcnt", 128'(drop_cnt), 128'(0));
        checkOutput("bp_derr", 128'(drop_err), 128'(0));

        $display("[TB] timeout drop on bus 2, then bus 9 granted");
        applyStimulus((32'h1 << 2) | (32'h1 << 9), 5'd15, 1'b1, 1'b0);
        tick();
        checkOutput("to_sel", 128'(can_rec_select), 128'(2));
        tick();
        tick();
        checkOutput("to_ack", 128'(rec_ack), 128'(32'h1 << 2));
        repeat (TIMEOUT_CYC - 1) tick();
        checkOutput("to_last_valid", 128'(uplink_valid), 128'(1));
        checkOutput("to_last_derr", 128'(drop_err), 128'(0));
        tick();
        checkOutput("to_derr", 128'(drop_err), 128'(1));
        checkOutput("to_dcnt", 128'(drop_cnt), 128'(1));
        checkIdleOutputs("to_done");
        tick();
        checkOutput("to_next_sel", 128'(can_rec_select), 128'(9));
        checkOutput("to_derr_pulse", 128'(drop_err), 128'(0));
        uplink_ready = 1'b1;
        tick();
        tick();
        checkOutput("to_next_ack", 128'(rec_ack), 128'(32'h1 << 9));
        irq_can_rec = '0;
        tick();
        checkIdleOutputs("to_next_done");

        $display("[TB] ready on the expiry cycle");
        applyStimulus(32'h1 << 9, 5'd15, 1'b1, 1'b0);
        tick();
        checkOutput("edge_sel", 128'(can_rec_select), 128'(9));
        tick();
        tick();
        repeat (TIMEOUT_CYC - 1) tick();
        checkOutput("edge_valid", 128'(uplink_valid), 128'(1));
        uplink_ready = 1'b1;
        irq_can_rec  = '0;
        tick();
        checkOutput("edge_derr", 128'(drop_err), 128'(0));
        checkOutput("edge_dcnt", 128'(drop_cnt), 128'(1));
        checkIdleOutputs("edge_done");

        $display("[TB] enable low, then withdrawn request on bus 3");
        applyStimulus(32'h1 << 3, 5'd15, 1'b0, 1'b1);
        tick();
        tick();
        checkOutput("dis_busy", 128'(busy), 128'(0));
        checkOutput("dis_sel", 128'(can_rec_select), 128'(9));
        enable = 1'b1;
        tick();
        checkOutput("wd_sel", 128'(can_rec_select), 128'(3));
        irq_can_rec = '0;
        tick();
        checkOutput("wd_busy_capture", 128'(busy), 128'(1));
        tick();
        checkIdleOutputs("wd_done");

        $display("[TB] pointer after withdraw, then reset mid-send");
        applyStimulus((32'h1 << 5) | (32'h1 << 11), 5'd15, 1'b1, 1'b0);
        tick();
        checkOutput("wd_ptr_sel", 128'(can_rec_select), 128'(11));
        tick();
        tick();
        checkOutput("rs_valid", 128'(uplink_valid), 128'(1));
        rst = 1'b1;
        tick();
        checkResetOutputs("rs");
        rst = 1'b0;
        tick();
        checkOutput("rs_resel", 128'(can_rec_select), 128'(5));
        checkOutput("rs_busy", 128'(busy), 128'(1));

        $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
        $finish;
    end

endmodule

// File: doc/can_rec_uplink_arbiter.md
Name: can_rec_uplink_arbiter

Overview:
- Shares the single uplink path (CAN receive data to the e-link transmitter) among up to 32 CAN bus receivers.
- Uses round-robin arbitration over per-bus receive requests and drives the bus-select mux (can_rec_select).
- Captures the selected 76-bit frame and presents it to the e-link side with a valid/ready handshake.
- Guards the uplink with a timeout and a dropped-frame counter.
- Sits between the per-bus CAN controllers and the uplink e-link FIFO in mopshub_top_32bus.

Parameters:
- N_BUSES, 32, number of physical bus request lines (max supported 32).
- DATA_W, 76, width of one received CAN frame word.
- TIMEOUT_CYC, 1024, maximum cycles to wait for uplink_ready before a frame is dropped (must be ≥2).
- CNT_W, 16, width of the dropped-frame counter.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- enable  in  1  arbitration enable. Low: no new grants; a transfer in progress completes.
- n_buses  in  5  index of the highest active bus. Requests from buses above this index are masked.
- irq_can_rec  in  N_BUSES  per-bus receive request, level, held until acknowledged.
- data_rec_in  in  DATA_W  frame from the receive mux, valid one cycle after can_rec_select is stable.
- uplink_ready  in  1  e-link side can accept a frame.
- can_rec_select  out  5  selected bus index driving the receive mux.
- rec_ack  out  N_BUSES  one-hot, one-cycle acknowledge to the served bus.
- data_rec_uplink  out  DATA_W  captured frame.
- uplink_valid  out  1  data_rec_uplink is valid.
- busy  out  1  high in any state other than IDLE.
- drop_err  out  1  one-cycle pulse when a frame is dropped on timeout.
- drop_cnt  out  CNT_W  dropped-frame count, saturating.

Behaviour:
- Reset (synchronous, rst=1 at clk edge) forces all of the following to 0: can_rec_select, rec_ack, data_rec_uplink, uplink_valid, busy, drop_err, drop_cnt, rr pointer (ptr). State goes to IDLE. Reset mid-transfer abandons the frame with no ack and no drop count.
- Request mask: eligible = irq_can_rec & (bits 0..n_buses).
- Round-robin search starts at ptr, ascending, and wraps after n_buses to 0. If ptr>n_buses, the search starts at 0.
- IDLE:
  - If enable and eligible≠0: register can_rec_select=winner, go to SELECT.
  - Otherwise stay in IDLE.
- SELECT: one mux-settle cycle, then go to CAPTURE.
- CAPTURE:
  - If irq_can_rec[sel]=1: latch data_rec_uplink=data_rec_in, assert uplink_valid and rec_ack[sel] (registered, both visible next cycle), clear the timeout counter, go to SEND.
  - If irq_can_rec[sel]=0 (request withdrawn): return to IDLE with no ack and ptr unchanged.
- SEND:
  - rec_ack is high only on the first SEND cycle.
  - uplink_valid and data_rec_uplink are held stable until the handshake.
  - On uplink_valid & uplink_ready: uplink_valid=0 next cycle, ptr=sel+1 (wraps to 0 if sel≥n_buses), go to IDLE.
  - Otherwise the timeout counter increments. When it reaches TIMEOUT_CYC-1 without ready: uplink_valid=0, one-cycle drop_err pulse, drop_cnt+1 (saturates at all-ones), ptr advanced as above, go to IDLE.
  - If ready arrives in the same cycle as timeout expiry, the handshake wins: no drop.
- Latency: request seen in IDLE at cycle t gives select at t+1, rec_ack and uplink_valid at t+3. Minimum 4 cycles per frame back-to-back.
- enable falling mid-transfer has no effect until the return to IDLE.
- n_buses is sampled only in IDLE and at pointer update. Changing it mid-transfer does not abort the transfer.
- busy = (state≠IDLE), registered.
- drop_err and rec_ack are never high in the same cycle.

Test Plan:
- Single request: irq_can_rec=bit 4, data_rec_in=76'hABC, ready=1 → can_rec_select=4 at t+1; rec_ack[4] and uplink_valid=1 at t+3 with data 76'hABC; valid low at t+4.
- Fairness: bits 0, 5, 31 held, n_buses=31, ready=1 → grant order 0, 5, 31, 0, 5, with 4 cycles per grant.
- Masking: n_buses=7, only bit 12 requested → no grant, busy=0. Set n_buses=15 → bus 12 granted.
- Backpressure: ready=0 for 10 cycles then 1 → valid and data held stable for 10 cycles, single transfer, drop_cnt=0. With TIMEOUT_CYC=16 and ready=0 → drop_err pulse at the 16th SEND cycle, drop_cnt=1, next requester granted.
- Withdraw: bit 3 requested, deasserted during SELECT → no rec_ack, no valid, ptr unchanged, returns to IDLE.
- Reset mid-SEND: rst=1 for one cycle → all outputs 0 next cycle. Held request is re-served from bus 0 upward.
